// File: rtl/risc16_prog_loader_if.sv
// Byte-stream handshake into the Risc16 program loader.
// Latency: none (wires only).
// Backpressure: the loader (slave) drives in_ready; a byte moves when in_valid & in_ready.
interface risc16_prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/risc16_prog_loader.sv
// Loads a framed, checksummed byte stream into Risc16 instruction memory, holding the core until done.
// Latency: each word is written one clock after its low byte is accepted; done/error one clock after CSUM.
// Backpressure: in_ready depends only on state; up to one byte per cycle, no stall around memory writes.
module risc16_prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  risc16_prog_loader_if.slave  s_in,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [15:0]          imem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W:0]      words_loaded
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CSUM    = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  // Largest legal image: exactly fills the instruction memory.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                err_q, err_d;

  logic                in_ready_c;
  logic                busy_c;
  logic                done_c;
  logic                accept;
  logic [15:0]         len_full;
  logic                oversize;
  logic                len_zero;
  logic                last_word;
  logic                csum_ok;

  assign accept    = s_in.in_valid & in_ready_c;
  // Length as it will be once the LEN_LO byte lands.
  assign len_full  = {len_q[15:8], s_in.in_data};
  assign oversize  = {1'b0, len_full} > MAX_LEN;
  assign len_zero  = (len_full == 16'd0);
  // The word being completed now is the final one of the image.
  assign last_word = (17'(wl_q) + 17'd1) == {1'b0, len_q};
  // Checksum byte equals the XOR of all previous bytes when the running XOR cancels.
  assign csum_ok   = ((csum_q ^ s_in.in_data) == 8'h00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: frame parsing sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = LEN_HI;
      LEN_HI:  if (accept) state_d = LEN_LO;
      LEN_LO:  if (accept) state_d = oversize ? ERR : (len_zero ? CSUM : DATA_HI);
      DATA_HI: if (accept) state_d = DATA_LO;
      DATA_LO: if (accept) state_d = last_word ? CSUM : DATA_HI;
      CSUM:    if (accept) state_d = csum_ok ? DONE : ERR;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: stream ready and status strobes straight from state.
  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
      end
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: length, byte staging, checksum, write port, status flags.
  always_comb begin
    len_d   = len_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    err_d   = err_q;

    // A new load re-stalls the core and wipes the previous result.
    if (state_q == IDLE && start) begin
      len_d  = 16'd0;
      csum_d = 8'h00;
      wl_d   = '0;
      err_d  = 1'b0;
      hold_d = 1'b1;
    end

    if (accept) begin
      csum_d = csum_q ^ s_in.in_data;
      case (state_q)
        LEN_HI:  len_d[15:8] = s_in.in_data;
        LEN_LO:  len_d[7:0]  = s_in.in_data;
        DATA_HI: hi_d        = s_in.in_data;
        DATA_LO: begin
          // Word index equals the count written so far; the count moves with the write.
          we_d    = 1'b1;
          addr_d  = wl_q[ADDR_W-1:0];
          wdata_d = {hi_q, s_in.in_data};
          wl_d    = wl_q + 1'b1;
        end
        default: ;
      endcase
    end

    if (state_d == ERR)  err_d  = 1'b1;
    if (state_d == DONE) hold_d = 1'b0;
  end

  // Datapath registers; the core is held from reset until a good image lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      len_q   <= len_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign s_in.in_ready = in_ready_c;
  assign busy          = busy_c;
  assign done          = done_c;
  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_hold      = hold_q;
  assign error         = err_q;
  assign words_loaded  = wl_q;

endmodule

// File: tb/tb_risc16_prog_loader.sv
// Bench for risc16_prog_loader: directed frames plus random frames checked against a frame-level model.
// Latency: n/a.
// Backpressure: stream driver honours in_ready and inserts random idle gaps.
module tb_risc16_prog_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold, busy, done, error;
  logic [ADDR_W:0]   words_loaded;

  risc16_prog_loader_if bus();

  risc16_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_in(bus.slave),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]      frame[$];
  logic [7:0]      wr_addr[$];
  logic [15:0]     wr_data[$];
  logic [ADDR_W:0] wr_wl[$];
  int              done_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the write port and done strobe mid-cycle.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_wl.push_back(words_loaded);
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic build_frame(input int len, input bit bad);
    logic [7:0] cs;
    frame.delete();
    frame.push_back(8'(len >> 8));
    frame.push_back(8'(len));
    if (len <= (1 << ADDR_W)) begin
      for (int i = 0; i < 2 * len; i++) frame.push_back(8'($urandom));
      cs = 8'h00;
      foreach (frame[i]) cs = cs ^ frame[i];
      if (bad) cs = cs ^ 8'(1 + $urandom_range(0, 254));
      frame.push_back(cs);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit noise);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (noise && ($urandom_range(0, 3) == 0)) start = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check_val("ready_timeout", 32'd0, 32'd1);
      $fatal(1, "stream stalled");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  // Drive one load of 'frame' and compare every outcome with the frame-level model.
  task automatic run_load(input bit gaps, input bit noise);
    int         len;
    bit         over;
    int         exp_nwr;
    bit         exp_err;
    logic [7:0] cs;
    int         t;

    len  = {frame[0], frame[1]};
    over = len > (1 << ADDR_W);
    if (over) begin
      exp_nwr = 0;
      exp_err = 1'b1;
    end else begin
      exp_nwr = len;
      cs = 8'h00;
      for (int i = 0; i < frame.size() - 1; i++) cs = cs ^ frame[i];
      exp_err = (cs != frame[frame.size() - 1]);
    end

    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    done_cnt = 0;

    // Start coincides with a stray byte that must not be taken.
    @(posedge clk); #1;
    start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'($urandom);
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("start_busy", busy, 1'b1);
    check_val("start_hold", cpu_hold, 1'b1);
    check_val("start_err_clr", error, 1'b0);
    check_val("start_wl_clr", words_loaded, 0);
    @(posedge clk); #1;

    foreach (frame[i]) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      send_byte(frame[i], noise);
    end

    t = 0;
    @(negedge clk);
    while (!(done || error) && t < 10) begin
      @(negedge clk);
      t++;
    end
    check_val("end_done", done, !exp_err);
    check_val("end_error", error, exp_err);
    check_val("end_busy", busy, 1'b0);
    check_val("end_hold", cpu_hold, exp_err);
    @(negedge clk);
    check_val("idle_done", done, 1'b0);
    check_val("idle_ready", bus.in_ready, 1'b0);
    check_val("words_loaded", words_loaded, exp_nwr);
    check_val("done_pulses", done_cnt, exp_err ? 0 : 1);
    check_val("n_writes", wr_addr.size(), exp_nwr);
    if (wr_addr.size() == exp_nwr) begin
      for (int i = 0; i < exp_nwr; i++) begin
        check_val("wr_addr", wr_addr[i], i);
        check_val("wr_data", wr_data[i], {frame[2 + 2 * i], frame[3 + 2 * i]});
        check_val("wr_count", wr_wl[i], i + 1);
      end
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hold", cpu_hold, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_error", error, 1'b0);
    check_val("rst_we", imem_we, 1'b0);
    check_val("rst_wl", words_loaded, 0);
    check_val("rst_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;

    // Valid held in IDLE goes nowhere.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("idle_valid_ready", bus.in_ready, 1'b0);
      check_val("idle_valid_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_load(1'b0, 1'b0);
    frame = '{8'h00, 8'h00, 8'h00};
    run_load(1'b0, 1'b0);
    frame = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF};
    run_load(1'b0, 1'b0);
    frame = '{8'h01, 8'h01};
    run_load(1'b0, 1'b0);
    build_frame(256, 1'b0);
    run_load(1'b0, 1'b0);

    // Same frame back-to-back and with stalls plus ignored start pulses.
    build_frame(6, 1'b0);
    run_load(1'b0, 1'b0);
    run_load(1'b1, 1'b1);

    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 7) == 0) build_frame(257 + $urandom_range(0, 2000), 1'b0);
      else build_frame($urandom_range(0, 23), $urandom_range(0, 3) == 0);
      run_load($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    // Reset after word 3 of 10 abandons the load; a fresh load then works.
    build_frame(10, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(frame[i], 1'b0);
    t = 0;
    @(negedge clk);
    while (words_loaded != 3 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check_val("mid_words", words_loaded, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_hold", cpu_hold, 1'b1);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_wl", words_loaded, 0);
    check_val("mid_rst_we", imem_we, 1'b0);
    check_val("mid_rst_ready", bus.in_ready, 1'b0);
    check_val("mid_rst_error", error, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    build_frame(5, 1'b0);
    run_load(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
